// File: rtl/oled_spi_pkg.sv
// Shared constants for the OLED SPI frame transmitter and the bridge's receive-side decode.
// Frame = {header, payload}; header carries RESb in bit 2 and DCb in bit 1.
package oled_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int FRAME_BITS  = 16;
  localparam int HDR_RES_BIT = 2;
  localparam int HDR_DC_BIT  = 1;
  localparam logic [7:0] HDR_FIXED = 8'h00;

  function automatic logic [7:0] build_header(input logic res, input logic dc);
    logic [7:0] h;
    h              = HDR_FIXED;
    h[HDR_RES_BIT] = res;
    h[HDR_DC_BIT]  = dc;
    return h;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: load with a length N and done is high on the last of those N cycles.
// Idles at zero, so done stays high whenever nothing is being timed.
module spi_tick_gen #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_len - W'(1);
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/oled_spi_frame_tx.sv
// SPI mode-0 master emitting one 16-bit {header, payload} frame per handshake,
// with CS setup/hold/gap guard times sized for the bridge's input synchronisers.
module oled_spi_frame_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_DC,
  input  logic       TX_RES,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       SPI_CSb,
  output logic       SPI_SCK,
  output logic       SPI_MOSI
);
  import oled_spi_pkg::*;

  localparam int CNT_W = 16;

  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [4:0]              r_bitcnt;
  logic                    r_csb, r_sck, r_mosi, r_ready, r_busy;

  logic                    w_done, w_load, w_last;
  logic [CNT_W-1:0]        w_len;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_frame = {build_header(TX_RES, TX_DC), TX_DATA};
  assign w_last  = r_sck && (r_bitcnt == 5'(FRAME_BITS - 1));

  // The timer is reloaded on the same edge the FSM changes phase, so each phase
  // lasts exactly the loaded length.
  always_comb begin
    w_load = 1'b0;
    w_len  = CNT_W'(CLK_DIV);
    case (r_state)
      ST_IDLE:  begin w_load = TX_VALID; w_len = CNT_W'(CS_GAP); end
      ST_SETUP: w_load = w_done;
      ST_SHIFT: begin
        w_load = w_done;
        if (w_last) w_len = CNT_W'(CS_GAP);
      end
      ST_HOLD:  begin w_load = w_done; w_len = CNT_W'(CS_GAP); end
      default:  w_load = 1'b0;
    endcase
  end

  spi_tick_gen #(.W(CNT_W)) u_tick (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_load),
    .i_len  (w_len),
    .o_done (w_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_csb    <= 1'b1;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (TX_VALID) begin
          r_shreg  <= w_frame;
          r_bitcnt <= '0;
          r_csb    <= 1'b0;
          r_sck    <= 1'b0;
          r_mosi   <= w_frame[FRAME_BITS-1];
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= ST_SETUP;
        end
        ST_SETUP: if (w_done) r_state <= ST_SHIFT;
        ST_SHIFT: if (w_done) begin
          if (!r_sck) begin
            r_sck <= 1'b1;
          end else begin
            // End of high phase: next bit goes out while SCK is low again.
            r_sck    <= 1'b0;
            r_shreg  <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            r_mosi   <= r_shreg[FRAME_BITS-2];
            r_bitcnt <= r_bitcnt + 5'd1;
            if (w_last) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: if (w_done) begin
          r_csb   <= 1'b1;
          r_state <= ST_GAP;
        end
        ST_GAP: if (w_done) begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign TX_READY = r_ready;
  assign BUSY     = r_busy;
  assign SPI_CSb  = r_csb;
  assign SPI_SCK  = r_sck;
  assign SPI_MOSI = r_mosi;

endmodule
